// File: rtl/axis_pkg.sv
// Shared types and default widths for the AXI-Stream traffic blocks.
package axis_pkg;

   localparam int AXIS_DATA_W = 8;
   localparam int AXIS_LEN_W  = 8;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      SEND = 1'b1
   } pktgen_state_t;

endpackage

// File: rtl/axis_pkt_gen_chk.sv
// Protocol checker for axis_pkt_gen: stream stability under backpressure,
// single-cycle done pulse and no valid data while idle.
module axis_pkt_gen_chk
   import axis_pkg::*;
#(
   parameter int WIDTH = AXIS_DATA_W
) (
   input logic              clk,
   input logic              rst,
   input pktgen_state_t     state,
   input logic              tvalid,
   input logic              tready,
   input logic [WIDTH-1:0]  tdata,
   input logic              tlast,
   input logic              done
);

   logic             stall_r;
   logic [WIDTH-1:0] tdata_r;
   logic             tlast_r;
   logic             done_r;

   // Remember the previous cycle and check the current one against it
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_r <= 1'b0;
         tdata_r <= '0;
         tlast_r <= 1'b0;
         done_r  <= 1'b0;
      end else begin
         stall_r <= tvalid && !tready;
         tdata_r <= tdata;
         tlast_r <= tlast;
         done_r  <= done;
         if (stall_r) begin
            assert (tvalid && (tdata == tdata_r) && (tlast == tlast_r))
               else $error("axis_pkt_gen_chk: stream changed under backpressure");
         end
         assert (!(done && done_r))
            else $error("axis_pkt_gen_chk: done held longer than one cycle");
         assert (!((state == IDLE) && tvalid))
            else $error("axis_pkt_gen_chk: tvalid asserted while idle");
      end
   end

endmodule

// File: rtl/axis_pkt_gen.sv
// AXI-Stream source: turns a len/seed/step command into a framed stream of
// arithmetic-sequence beats with TLAST on the final beat.
module axis_pkt_gen
   import axis_pkg::*;
#(
   parameter int WIDTH = AXIS_DATA_W,
   parameter int LEN_W = AXIS_LEN_W,
   parameter int CNT_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [LEN_W-1:0]  cmd_len,
   input  logic [WIDTH-1:0]  cmd_seed,
   input  logic [WIDTH-1:0]  cmd_step,
   output logic [WIDTH-1:0]  m_axis_tdata,
   output logic              m_axis_tvalid,
   output logic              m_axis_tlast,
   input  logic              m_axis_tready,
   output logic              done,
   output logic [CNT_W-1:0]  frame_cnt
);

   localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);
   localparam logic [LEN_W-1:0] LEN_ZERO = LEN_W'(0);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   pktgen_state_t    state_r;
   logic [LEN_W-1:0] len_r;
   logic [LEN_W-1:0] idx_r;
   logic [WIDTH-1:0] step_r;
   logic [WIDTH-1:0] tdata_r;
   logic             tvalid_r;
   logic             tlast_r;
   logic             done_r;
   logic [CNT_W-1:0] frame_cnt_r;

   assign cmd_ready     = (state_r == IDLE) && !rst;
   assign m_axis_tdata  = tdata_r;
   assign m_axis_tvalid = tvalid_r;
   assign m_axis_tlast  = tlast_r;
   assign done          = done_r;
   assign frame_cnt     = frame_cnt_r;

   // Frame FSM and beat datapath; every output comes straight from a register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= IDLE;
         len_r       <= '0;
         idx_r       <= '0;
         step_r      <= '0;
         tdata_r     <= '0;
         tvalid_r    <= 1'b0;
         tlast_r     <= 1'b0;
         done_r      <= 1'b0;
         frame_cnt_r <= '0;
      end else begin
         done_r <= 1'b0;
         case (state_r)
            IDLE: begin
               if (cmd_valid) begin
                  // A zero-length command completes immediately without a beat
                  if (cmd_len == LEN_ZERO) begin
                     done_r <= 1'b1;
                  end else begin
                     len_r    <= cmd_len;
                     step_r   <= cmd_step;
                     idx_r    <= '0;
                     tdata_r  <= cmd_seed;
                     tvalid_r <= 1'b1;
                     tlast_r  <= (cmd_len == LEN_ONE);
                     state_r  <= SEND;
                  end
               end
            end
            SEND: begin
               if (tvalid_r && m_axis_tready) begin
                  if (tlast_r) begin
                     tvalid_r    <= 1'b0;
                     tlast_r     <= 1'b0;
                     done_r      <= 1'b1;
                     frame_cnt_r <= frame_cnt_r + CNT_ONE;
                     state_r     <= IDLE;
                  end else begin
                     tdata_r <= tdata_r + step_r;
                     idx_r   <= idx_r + LEN_ONE;
                     tlast_r <= ((idx_r + LEN_ONE) == (len_r - LEN_ONE));
                  end
               end
            end
            default: begin
               state_r  <= IDLE;
               tvalid_r <= 1'b0;
               tlast_r  <= 1'b0;
            end
         endcase
      end
   end

   axis_pkt_gen_chk #(
      .WIDTH (WIDTH)
   ) u_chk (
      .clk    (clk),
      .rst    (rst),
      .state  (state_r),
      .tvalid (tvalid_r),
      .tready (m_axis_tready),
      .tdata  (tdata_r),
      .tlast  (tlast_r),
      .done   (done_r)
   );

endmodule

// File: tb/tb_axis_pkt_gen.sv
// Directed self-checking bench for axis_pkt_gen with hand-computed beats.
module tb_axis_pkt_gen;

   logic        clk;
   logic        rst;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [7:0]  cmd_len;
   logic [7:0]  cmd_seed;
   logic [7:0]  cmd_step;
   logic [7:0]  m_axis_tdata;
   logic        m_axis_tvalid;
   logic        m_axis_tlast;
   logic        m_axis_tready;
   logic        done;
   logic [15:0] frame_cnt;

   int vectors;
   int miscompares;
   int exp_cnt;

   axis_pkt_gen #(
      .WIDTH (8),
      .LEN_W (8),
      .CNT_W (16)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .cmd_valid     (cmd_valid),
      .cmd_ready     (cmd_ready),
      .cmd_len       (cmd_len),
      .cmd_seed      (cmd_seed),
      .cmd_step      (cmd_step),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tlast  (m_axis_tlast),
      .m_axis_tready (m_axis_tready),
      .done          (done),
      .frame_cnt     (frame_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      vectors++;
      assert (observed === expected) else begin
         miscompares++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Issue a command with tready held high and check every beat plus the done cycle.
   task automatic run_frame(input logic [7:0] len, input logic [7:0] seed, input logic [7:0] step);
      logic [7:0] e;
      m_axis_tready = 1'b1;
      cmd_valid = 1'b1;
      cmd_len   = len;
      cmd_seed  = seed;
      cmd_step  = step;
      tick();
      cmd_valid = 1'b0;
      e = seed;
      for (int i = 0; i < int'(len); i++) begin
         chk("beat_valid", 32'(m_axis_tvalid), 32'(1));
         chk("beat_data",  32'(m_axis_tdata),  32'(e));
         chk("beat_last",  32'(m_axis_tlast),  32'(i == int'(len) - 1));
         chk("beat_ready", 32'(cmd_ready),     32'(0));
         e = e + step;
         tick();
      end
      exp_cnt++;
      chk("end_valid", 32'(m_axis_tvalid), 32'(0));
      chk("end_done",  32'(done),          32'(1));
      chk("end_cnt",   32'(frame_cnt),     32'(exp_cnt));
      tick();
      chk("post_done",  32'(done),      32'(0));
      chk("post_ready", 32'(cmd_ready), 32'(1));
   endtask

   initial begin
      logic [6:0] pat;
      logic [7:0] e;
      int k;
      vectors = 0;
      miscompares = 0;
      exp_cnt = 0;
      rst = 1'b1;
      cmd_valid = 1'b0;
      cmd_len = 8'h00;
      cmd_seed = 8'h00;
      cmd_step = 8'h00;
      m_axis_tready = 1'b0;

      // Reset held for two cycles
      tick();
      tick();
      chk("rst_valid", 32'(m_axis_tvalid), 32'(0));
      chk("rst_last",  32'(m_axis_tlast),  32'(0));
      chk("rst_data",  32'(m_axis_tdata),  32'(0));
      chk("rst_done",  32'(done),          32'(0));
      chk("rst_cnt",   32'(frame_cnt),     32'(0));
      chk("rst_ready", 32'(cmd_ready),     32'(0));
      rst = 1'b0;
      #1;
      chk("idle_ready", 32'(cmd_ready),     32'(1));
      chk("idle_valid", 32'(m_axis_tvalid), 32'(0));

      // Basic 4-beat frame: 0x10 0x13 0x16 0x19
      run_frame(8'd4, 8'h10, 8'h03);

      // Same frame under backpressure pattern 1,0,0,1,0,1,1
      pat = 7'b1101001;
      m_axis_tready = 1'b0;
      cmd_valid = 1'b1;
      cmd_len = 8'd4;
      cmd_seed = 8'h10;
      cmd_step = 8'h03;
      tick();
      cmd_valid = 1'b0;
      k = 0;
      e = 8'h10;
      for (int c = 0; c < 7; c++) begin
         m_axis_tready = pat[c];
         chk("bp_valid", 32'(m_axis_tvalid), 32'(1));
         chk("bp_data",  32'(m_axis_tdata),  32'(e));
         chk("bp_last",  32'(m_axis_tlast),  32'(k == 3));
         tick();
         if (pat[c]) begin
            k++;
            e = e + 8'h03;
         end
      end
      exp_cnt++;
      chk("bp_beats", 32'(k), 32'(4));
      chk("bp_end_valid", 32'(m_axis_tvalid), 32'(0));
      chk("bp_end_done",  32'(done),          32'(1));
      chk("bp_end_cnt",   32'(frame_cnt),     32'(exp_cnt));
      tick();

      // Wrap-around arithmetic and single-beat frame
      run_frame(8'd3, 8'hFE, 8'h01);
      run_frame(8'd1, 8'h5A, 8'h07);

      // Zero-length command: done only
      cmd_valid = 1'b1;
      cmd_len = 8'd0;
      cmd_seed = 8'hAA;
      tick();
      cmd_valid = 1'b0;
      chk("z_valid", 32'(m_axis_tvalid), 32'(0));
      chk("z_done",  32'(done),          32'(1));
      chk("z_cnt",   32'(frame_cnt),     32'(exp_cnt));
      chk("z_ready", 32'(cmd_ready),     32'(1));
      tick();
      chk("z_done2",  32'(done),          32'(0));
      chk("z_valid2", 32'(m_axis_tvalid), 32'(0));

      // Command offered during SEND is ignored
      m_axis_tready = 1'b0;
      cmd_valid = 1'b1;
      cmd_len = 8'd2;
      cmd_seed = 8'h20;
      cmd_step = 8'h10;
      tick();
      cmd_len = 8'd5;
      cmd_seed = 8'h77;
      cmd_step = 8'h01;
      chk("ign_ready", 32'(cmd_ready),    32'(0));
      chk("ign_data0", 32'(m_axis_tdata), 32'(8'h20));
      tick();
      chk("ign_hold", 32'(m_axis_tdata), 32'(8'h20));
      chk("ign_last0", 32'(m_axis_tlast), 32'(0));
      m_axis_tready = 1'b1;
      tick();
      cmd_valid = 1'b0;
      chk("ign_data1", 32'(m_axis_tdata), 32'(8'h30));
      chk("ign_last1", 32'(m_axis_tlast), 32'(1));
      tick();
      exp_cnt++;
      chk("ign_done", 32'(done),      32'(1));
      chk("ign_cnt",  32'(frame_cnt), 32'(exp_cnt));
      tick();
      chk("ign_novalid", 32'(m_axis_tvalid), 32'(0));

      // Reset while beat 2 of a 5-beat frame is stalled
      m_axis_tready = 1'b1;
      cmd_valid = 1'b1;
      cmd_len = 8'd5;
      cmd_seed = 8'h40;
      cmd_step = 8'h02;
      tick();
      cmd_valid = 1'b0;
      tick();
      tick();
      m_axis_tready = 1'b0;
      chk("mr_beat2", 32'(m_axis_tdata), 32'(8'h44));
      tick();
      chk("mr_stall", 32'(m_axis_tdata), 32'(8'h44));
      rst = 1'b1;
      tick();
      chk("mr_valid", 32'(m_axis_tvalid), 32'(0));
      chk("mr_cnt",   32'(frame_cnt),     32'(0));
      chk("mr_done",  32'(done),          32'(0));
      rst = 1'b0;
      tick();
      chk("mr_done2", 32'(done),          32'(0));
      chk("mr_idle",  32'(m_axis_tvalid), 32'(0));
      exp_cnt = 0;
      run_frame(8'd2, 8'h01, 8'h01);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
